e1_rx_bd_fifo: RTL and testbench

Buffer-descriptor manager placed directly downstream of the E1 RX top-level.
- Software queues free multiframe slot indexes.
- The block presents the head slot to the receiver on bd_mf/bd_valid.
- On bd_done, it retires the slot together with its CRC status into a completion queue that software drains.
- It counts bd_miss events, i.e. multiframes dropped because no free descriptor was available.

---
 rtl/e1_rx_bd_fifo.sv | 116 +++++++++++
 tb/tb_e1_rx_bd_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/e1_rx_bd_fifo.sv
// Free-descriptor and completion queues for the E1 receiver multiframe slots.
// Optional macro E1_RX_BD_FLUSH_EN adds sw_free_flush to empty the free queue.
module e1_rx_bd_fifo #(
  parameter int unsigned MFW       = 7,
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [MFW-1:0]       bd_mf,
  output logic                 bd_valid,
  input  logic [1:0]           bd_crc_e,
  input  logic                 bd_done,
  input  logic                 bd_miss,
  input  logic [MFW-1:0]       sw_free_mf,
  input  logic                 sw_free_we,
`ifdef E1_RX_BD_FLUSH_EN
  input  logic                 sw_free_flush,
`endif
  output logic                 sw_free_full,
  output logic [DEPTH_LOG:0]   sw_free_level,
  output logic [MFW-1:0]       sw_done_mf,
  output logic [1:0]           sw_done_crc_e,
  output logic                 sw_done_valid,
  input  logic                 sw_done_re,
  output logic [DEPTH_LOG:0]   sw_done_level,
  output logic [15:0]          miss_cnt,
  input  logic                 miss_clr,
  output logic                 err_free_ovf,
  output logic                 err_done_ovf,
  input  logic                 err_clr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [MFW-1:0]     free_mem [DEPTH];
  logic [MFW+1:0]     done_mem [DEPTH];
  logic [DEPTH_LOG:0] free_wp, free_rp, done_wp, done_rp;
  logic               done_full;
  logic               flush;
  logic               free_push, free_pop, free_ovf;
  logic               done_push, done_pop, done_ovf;
  logic [MFW+1:0]     done_head;

`ifdef E1_RX_BD_FLUSH_EN
  assign flush = sw_free_flush;
`else
  assign flush = 1'b0;
`endif

  assign sw_free_level = free_wp - free_rp;
  assign sw_free_full  = sw_free_level[DEPTH_LOG];
  assign bd_valid      = |sw_free_level;
  assign bd_mf         = free_mem[free_rp[DEPTH_LOG-1:0]];

  assign sw_done_level = done_wp - done_rp;
  assign done_full     = sw_done_level[DEPTH_LOG];
  assign sw_done_valid = |sw_done_level;
  assign done_head     = done_mem[done_rp[DEPTH_LOG-1:0]];
  assign sw_done_mf    = done_head[MFW+1:2];
  assign sw_done_crc_e = done_head[1:0];

  // A same-cycle pop frees a slot, so a push into a full queue is still accepted.
  assign free_pop  = bd_done & bd_valid & ~flush;
  assign free_push = sw_free_we & (~sw_free_full | free_pop) & ~flush;
  assign free_ovf  = sw_free_we & sw_free_full & ~free_pop & ~flush;

  assign done_pop  = sw_done_re & sw_done_valid;
  assign done_push = free_pop & (~done_full | done_pop);
  assign done_ovf  = free_pop & done_full & ~done_pop;

  always_ff @(posedge clk) begin
    if (free_push) free_mem[free_wp[DEPTH_LOG-1:0]] <= sw_free_mf;
    if (done_push) done_mem[done_wp[DEPTH_LOG-1:0]] <= {bd_mf, bd_crc_e};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      free_wp <= '0;
      free_rp <= '0;
    end else begin
      if (free_push) free_wp <= free_wp + 1'b1;
      if (free_pop)  free_rp <= free_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_wp <= '0;
      done_rp <= '0;
    end else begin
      if (done_push) done_wp <= done_wp + 1'b1;
      if (done_pop)  done_rp <= done_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (miss_clr) begin
      miss_cnt <= bd_miss ? 16'd1 : 16'd0;
    end else if (bd_miss && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_free_ovf <= 1'b0;
      err_done_ovf <= 1'b0;
    end else begin
      err_free_ovf <= (err_free_ovf & ~err_clr) | free_ovf;
      err_done_ovf <= (err_done_ovf & ~err_clr) | done_ovf;
    end
  end

endmodule

// File: tb/tb_e1_rx_bd_fifo.sv
// Directed bench for e1_rx_bd_fifo; completion entries are checked by a scoreboard monitor.
module tb_e1_rx_bd_fifo;

  localparam int unsigned MFW = 7;
  localparam int unsigned DL  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [MFW-1:0] bd_mf;
  logic           bd_valid;
  logic [1:0]     bd_crc_e = '0;
  logic           bd_done = 1'b0;
  logic           bd_miss = 1'b0;
  logic [MFW-1:0] sw_free_mf = '0;
  logic           sw_free_we = 1'b0;
  logic           sw_free_flush = 1'b0;
  logic           sw_free_full;
  logic [DL:0]    sw_free_level;
  logic [MFW-1:0] sw_done_mf;
  logic [1:0]     sw_done_crc_e;
  logic           sw_done_valid;
  logic           sw_done_re = 1'b0;
  logic [DL:0]    sw_done_level;
  logic [15:0]    miss_cnt;
  logic           miss_clr = 1'b0;
  logic           err_free_ovf;
  logic           err_done_ovf;
  logic           err_clr = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [MFW+1:0] exp_q [$];

  e1_rx_bd_fifo #(.MFW(MFW), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst),
    .bd_mf(bd_mf), .bd_valid(bd_valid), .bd_crc_e(bd_crc_e),
    .bd_done(bd_done), .bd_miss(bd_miss),
    .sw_free_mf(sw_free_mf), .sw_free_we(sw_free_we),
`ifdef E1_RX_BD_FLUSH_EN
    .sw_free_flush(sw_free_flush),
`endif
    .sw_free_full(sw_free_full), .sw_free_level(sw_free_level),
    .sw_done_mf(sw_done_mf), .sw_done_crc_e(sw_done_crc_e),
    .sw_done_valid(sw_done_valid), .sw_done_re(sw_done_re),
    .sw_done_level(sw_done_level),
    .miss_cnt(miss_cnt), .miss_clr(miss_clr),
    .err_free_ovf(err_free_ovf), .err_done_ovf(err_done_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_free(input logic [MFW-1:0] v);
    sw_free_mf = v;
    sw_free_we = 1'b1;
    tick();
    sw_free_we = 1'b0;
  endtask

  task automatic do_done(input logic [1:0] crc);
    bd_crc_e = crc;
    bd_done  = 1'b1;
    tick();
    bd_done  = 1'b0;
    bd_crc_e = 2'b00;
  endtask

  // Scoreboard monitor: every completion read by software is checked against the queue.
  always @(negedge clk) begin
    if (sw_done_re && sw_done_valid) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {sw_done_mf, sw_done_crc_e}, 32'hDEAD);
      end else begin
        chk("done_entry", {sw_done_mf, sw_done_crc_e}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_bd_valid", bd_valid, 0);
    chk("rst_done_valid", sw_done_valid, 0);
    chk("rst_free_full", sw_free_full, 0);
    chk("rst_free_level", sw_free_level, 0);
    chk("rst_done_level", sw_done_level, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_errs", {err_free_ovf, err_done_ovf}, 0);

    // Basic push and completion
    push_free(7'd3);
    chk("first_valid", bd_valid, 1);
    push_free(7'd5);
    push_free(7'd9);
    chk("basic_bd_mf", bd_mf, 3);
    chk("basic_level", sw_free_level, 3);
    exp_q.push_back({7'd3, 2'b10});
    do_done(2'b10);
    chk("basic_next_mf", bd_mf, 5);
    chk("basic_done_valid", sw_done_valid, 1);
    chk("basic_done_mf", sw_done_mf, 3);
    chk("basic_done_crc", sw_done_crc_e, 2'b10);
    chk("basic_free_level", sw_free_level, 2);
    sw_done_re = 1'b1; tick(); sw_done_re = 1'b0;
    chk("basic_drained", sw_done_level, 0);

    // Free queue overflow
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) push_free(7'(20 + i));
    chk("fill_full", sw_free_full, 1);
    chk("fill_level", sw_free_level, 16);
    chk("fill_no_ovf", err_free_ovf, 0);
    push_free(7'd36);
    chk("ovf_flag", err_free_ovf, 1);
    chk("ovf_level", sw_free_level, 16);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", err_free_ovf, 0);

    // Full free queue: push and pop in the same cycle
    sw_free_mf = 7'd40; sw_free_we = 1'b1;
    exp_q.push_back({7'd20, 2'b01});
    do_done(2'b01);
    sw_free_we = 1'b0;
    chk("simul_free_level", sw_free_level, 16);
    chk("simul_free_no_ovf", err_free_ovf, 0);
    chk("simul_free_mf", bd_mf, 21);

    // Fill the completion queue; slot 36 must never appear
    for (int i = 0; i < 15; i++) begin
      chk("pop_seq_mf", bd_mf, 21 + i);
      exp_q.push_back({7'(21 + i), 2'(i)});
      do_done(2'(i));
    end
    chk("after_pop_mf", bd_mf, 40);
    chk("done_filled", sw_done_level, 16);
    chk("done_no_ovf", err_done_ovf, 0);
    do_done(2'b11);
    chk("done_ovf_flag", err_done_ovf, 1);
    chk("done_ovf_level", sw_done_level, 16);
    chk("done_ovf_free_level", sw_free_level, 0);
    chk("done_ovf_head", {sw_done_mf, sw_done_crc_e}, {7'd20, 2'b01});

    // bd_done while no descriptor is available
    do_done(2'b10);
    chk("empty_done_free", sw_free_level, 0);
    chk("empty_done_done", sw_done_level, 16);

    // Completion queue: read and completion in the same cycle
    push_free(7'd50);
    exp_q.push_back({7'd50, 2'b10});
    sw_done_re = 1'b1;
    do_done(2'b10);
    sw_done_re = 1'b0;
    chk("simul_done_level", sw_done_level, 16);
    chk("simul_done_free", sw_free_level, 0);

    sw_done_re = 1'b1;
    repeat (17) tick();
    sw_done_re = 1'b0;
    chk("drain_level", sw_done_level, 0);
    chk("drain_valid", sw_done_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Push into empty queue concurrent with bd_done must not pop
    sw_free_mf = 7'd60; sw_free_we = 1'b1;
    do_done(2'b01);
    sw_free_we = 1'b0;
    chk("empty_push_done_level", sw_free_level, 1);
    chk("empty_push_done_mf", bd_mf, 60);
    chk("empty_push_done_cq", sw_done_level, 0);

    // Miss counter
    repeat (3) begin bd_miss = 1'b1; tick(); bd_miss = 1'b0; end
    chk("miss_3", miss_cnt, 3);
    miss_clr = 1'b1; bd_miss = 1'b1; tick(); miss_clr = 1'b0;
    chk("miss_clr_hit", miss_cnt, 1);
    repeat (65534) tick();
    chk("miss_max", miss_cnt, 16'hFFFF);
    tick();
    bd_miss = 1'b0;
    chk("miss_sat", miss_cnt, 16'hFFFF);

`ifdef E1_RX_BD_FLUSH_EN
    push_free(7'd61); push_free(7'd62); push_free(7'd63);
    chk("flush_pre_level", sw_free_level, 4);
    sw_free_flush = 1'b1; sw_free_mf = 7'd64; sw_free_we = 1'b1;
    do_done(2'b11);
    sw_free_flush = 1'b0; sw_free_we = 1'b0;
    chk("flush_level", sw_free_level, 0);
    chk("flush_valid", bd_valid, 0);
    chk("flush_done_level", sw_done_level, 0);
`endif

    // Reset mid-operation
    push_free(7'd70);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_valid", bd_valid, 0);
    chk("midrst_level", sw_free_level, 0);
    chk("midrst_miss", miss_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
